// File: rtl/perspective_projector.sv
// Camera-space to screen-space projector: shared 32-step restoring divider for 1/z, then scale and centre.
// Optional near-plane culling enabled by defining PERSPECTIVE_NEAR_CULL_EN (otherwise z is clamped to NEAR_Z).
package perspective_pkg;
  typedef logic signed [31:0] q16_16_t;
  typedef struct packed { q16_16_t x; q16_16_t y; q16_16_t z; } vec3_t;
  typedef struct packed { vec3_t pos; logic [31:0] color; } vertex_t;
  typedef struct packed { vertex_t [2:0] v; } triangle_t;
endpackage

module perspective_projector
  import perspective_pkg::*;
#(
  parameter int      SCREEN_W = 320,
  parameter int      SCREEN_H = 240,
  parameter q16_16_t FOCAL    = 32'h00A0_0000,
  parameter q16_16_t NEAR_Z   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  triangle_t   triangle,
  input  logic        in_valid,
  output logic        in_ready,
  output triangle_t   out_triangle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] cull_count
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_MUL, S_SCALE, S_OUT} state_t;

  localparam logic signed [63:0] CENTER_X = 64'(SCREEN_W / 2) <<< 16;
  localparam logic signed [63:0] CENTER_Y = 64'(SCREEN_H / 2) <<< 16;

  function automatic q16_16_t sat64(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF)      return 32'h7FFF_FFFF;
    else if (v < 64'shFFFF_FFFF_8000_0000) return 32'h8000_0000;
    else                                   return v[31:0];
  endfunction

  state_t      state_q, state_d;
  triangle_t   tri_q, tri_d;
  triangle_t   out_tri_q, out_tri_d;
  logic [1:0]  vert_idx_q, vert_idx_d;
  logic [31:0] div_rem_q, div_rem_d;
  logic [31:0] div_quo_q, div_quo_d;
  logic [31:0] div_z_q, div_z_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  q16_16_t     tx_q, tx_d, ty_q, ty_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] cull_count_q, cull_count_d;

  vertex_t            cur_v;
  logic [32:0]        rem_sh;
  logic signed [63:0] mul_x, mul_y, scl_x, scl_y, px, py;
  q16_16_t            sx, sy;

  assign cur_v        = tri_q.v[vert_idx_q];
  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign out_valid    = out_valid_q;
  assign out_triangle = out_tri_q;
  assign cull_count   = cull_count_q;

  always_comb begin
    state_d      = state_q;
    tri_d        = tri_q;
    out_tri_d    = out_tri_q;
    vert_idx_d   = vert_idx_q;
    div_rem_d    = div_rem_q;
    div_quo_d    = div_quo_q;
    div_z_d      = div_z_q;
    div_cnt_d    = div_cnt_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    out_valid_d  = out_valid_q;
    cull_count_d = cull_count_q;

    rem_sh = {div_rem_q, 1'b0};
    mul_x  = 64'(cur_v.pos.x) * $signed({32'b0, div_quo_q});
    mul_y  = 64'(cur_v.pos.y) * $signed({32'b0, div_quo_q});
    scl_x  = 64'(FOCAL) * 64'(tx_q);
    scl_y  = 64'(FOCAL) * 64'(ty_q);
    sx     = sat64(scl_x >>> 16);
    sy     = sat64(scl_y >>> 16);
    px     = CENTER_X + 64'(sx);
    py     = CENTER_Y - 64'(sy);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tri_d      = triangle;
          vert_idx_d = '0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        // Dividend 2^32: its leading 1 is preloaded into the remainder, so 32 steps suffice.
        div_rem_d = 32'd1;
        div_quo_d = '0;
        div_cnt_d = '0;
        div_z_d   = cur_v.pos.z;
        state_d   = S_DIV;
        if (cur_v.pos.z < NEAR_Z) begin
`ifdef PERSPECTIVE_NEAR_CULL_EN
          state_d      = S_IDLE;
          cull_count_d = cull_count_q + 16'd1;
`else
          div_z_d = NEAR_Z;
`endif
        end
      end
      S_DIV: begin
        if (rem_sh >= {1'b0, div_z_q}) begin
          div_rem_d = 32'(rem_sh - {1'b0, div_z_q});
          div_quo_d = {div_quo_q[30:0], 1'b1};
        end else begin
          div_rem_d = rem_sh[31:0];
          div_quo_d = {div_quo_q[30:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) state_d = S_MUL;
      end
      S_MUL: begin
        tx_d    = sat64(mul_x >>> 16);
        ty_d    = sat64(mul_y >>> 16);
        state_d = S_SCALE;
      end
      S_SCALE: begin
        out_tri_d.v[vert_idx_q].pos.x = sat64(px);
        out_tri_d.v[vert_idx_q].pos.y = sat64(py);
        out_tri_d.v[vert_idx_q].pos.z = cur_v.pos.z;
        out_tri_d.v[vert_idx_q].color = cur_v.color;
        if (vert_idx_q == 2'd2) begin
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          vert_idx_d = vert_idx_q + 2'd1;
          state_d    = S_CHECK;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tri_q        <= '0;
      out_tri_q    <= '0;
      vert_idx_q   <= '0;
      div_rem_q    <= '0;
      div_quo_q    <= '0;
      div_z_q      <= '0;
      div_cnt_q    <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      out_valid_q  <= 1'b0;
      cull_count_q <= '0;
    end else begin
      state_q      <= state_d;
      tri_q        <= tri_d;
      out_tri_q    <= out_tri_d;
      vert_idx_q   <= vert_idx_d;
      div_rem_q    <= div_rem_d;
      div_quo_q    <= div_quo_d;
      div_z_q      <= div_z_d;
      div_cnt_q    <= div_cnt_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      out_valid_q  <= out_valid_d;
      cull_count_q <= cull_count_d;
    end
  end

endmodule
